// File: rtl/alu_unit_pkg.sv
// Shared types and constants for the integer execution stage: word/ROB types,
// op-code encodings and the result-queue entry layout.
package alu_unit_pkg;

  localparam int unsigned WORD    = 32;
  localparam int unsigned ROB_BIT = 4;
  localparam int unsigned OPT_BIT = 6;
  localparam int unsigned Q_DEPTH = 2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [WORD-1:0]    word_t;
  typedef logic [ROB_BIT-1:0] ROB_IDX;
  typedef logic [OPT_BIT-1:0] INST_OPT;

  localparam word_t  ZERO_WORD    = '0;
  localparam ROB_IDX ZERO_ROB_IDX = '0;

  localparam INST_OPT OPT_NONE  = 6'd0;
  localparam INST_OPT OPT_LUI   = 6'd1;
  localparam INST_OPT OPT_AUIPC = 6'd2;
  localparam INST_OPT OPT_JAL   = 6'd3;
  localparam INST_OPT OPT_JALR  = 6'd4;
  localparam INST_OPT OPT_BEQ   = 6'd5;
  localparam INST_OPT OPT_BNE   = 6'd6;
  localparam INST_OPT OPT_BLT   = 6'd7;
  localparam INST_OPT OPT_BGE   = 6'd8;
  localparam INST_OPT OPT_BLTU  = 6'd9;
  localparam INST_OPT OPT_BGEU  = 6'd10;
  localparam INST_OPT OPT_ADD   = 6'd11;
  localparam INST_OPT OPT_SUB   = 6'd12;
  localparam INST_OPT OPT_SLL   = 6'd13;
  localparam INST_OPT OPT_SLT   = 6'd14;
  localparam INST_OPT OPT_SLTU  = 6'd15;
  localparam INST_OPT OPT_XOR   = 6'd16;
  localparam INST_OPT OPT_SRL   = 6'd17;
  localparam INST_OPT OPT_SRA   = 6'd18;
  localparam INST_OPT OPT_OR    = 6'd19;
  localparam INST_OPT OPT_AND   = 6'd20;
  localparam INST_OPT OPT_ADDI  = 6'd21;
  localparam INST_OPT OPT_SLTI  = 6'd22;
  localparam INST_OPT OPT_SLTIU = 6'd23;
  localparam INST_OPT OPT_XORI  = 6'd24;
  localparam INST_OPT OPT_ORI   = 6'd25;
  localparam INST_OPT OPT_ANDI  = 6'd26;
  localparam INST_OPT OPT_SLLI  = 6'd27;
  localparam INST_OPT OPT_SRLI  = 6'd28;
  localparam INST_OPT OPT_SRAI  = 6'd29;

  typedef struct packed {
    ROB_IDX rob_idx;
    word_t  val;
    logic   jump;
    word_t  target;
  } alu_res_t;

endpackage

// File: rtl/alu_unit_if.sv
// Dispatch (RS -> ALU) and CDB broadcast channel of the integer execution stage.
interface alu_unit_if;
  import alu_unit_pkg::*;

  logic    alu_ena;
  INST_OPT alu_opt;
  word_t   alu_val1;
  word_t   alu_val2;
  word_t   alu_imm;
  word_t   alu_pc;
  ROB_IDX  alu_rob_idx;
  logic    alu_full;

  logic    cdb_gnt;
  logic    cdb_alu_valid;
  ROB_IDX  cdb_alu_src;
  word_t   cdb_alu_val;
  logic    cdb_alu_jump;
  word_t   cdb_alu_target;

  modport master (
    output alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_idx, cdb_gnt,
    input  alu_full, cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_alu_jump, cdb_alu_target
  );

  modport slave (
    input  alu_ena, alu_opt, alu_val1, alu_val2, alu_imm, alu_pc, alu_rob_idx, cdb_gnt,
    output alu_full, cdb_alu_valid, cdb_alu_src, cdb_alu_val, cdb_alu_jump, cdb_alu_target
  );
endinterface

// File: rtl/alu_unit_core.sv
// Combinational RV32I integer/branch/jump datapath: (opt, operands, pc) -> (val, jump, target).
module alu_core
  import alu_unit_pkg::*;
(
  input  INST_OPT opt,
  input  word_t   val1,
  input  word_t   val2,
  input  word_t   imm,
  input  word_t   pc,
  output word_t   val,
  output logic    jump,
  output word_t   target
);

  logic       is_imm;
  word_t      op_b;
  logic [4:0] shamt;
  word_t      br_tgt;
  word_t      jalr_sum;

  always_comb begin
    is_imm   = opt inside {OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
                           OPT_SLLI, OPT_SRLI, OPT_SRAI};
    op_b     = is_imm ? imm : val2;
    shamt    = op_b[4:0];
    br_tgt   = pc + imm;
    jalr_sum = val1 + imm;

    val    = ZERO_WORD;
    jump   = FALSE;
    target = ZERO_WORD;

    case (opt)
      OPT_ADD,  OPT_ADDI:  val = val1 + op_b;
      OPT_SUB:             val = val1 - op_b;
      OPT_SLL,  OPT_SLLI:  val = val1 << shamt;
      OPT_SLT,  OPT_SLTI:  val = WORD'($signed(val1) < $signed(op_b));
      OPT_SLTU, OPT_SLTIU: val = WORD'(val1 < op_b);
      OPT_XOR,  OPT_XORI:  val = val1 ^ op_b;
      OPT_SRL,  OPT_SRLI:  val = val1 >> shamt;
      OPT_SRA,  OPT_SRAI:  val = WORD'($signed(val1) >>> shamt);
      OPT_OR,   OPT_ORI:   val = val1 | op_b;
      OPT_AND,  OPT_ANDI:  val = val1 & op_b;
      OPT_LUI:             val = imm;
      OPT_AUIPC:           val = br_tgt;
      OPT_JAL: begin
        val    = pc + WORD'(4);
        jump   = TRUE;
        target = br_tgt;
      end
      OPT_JALR: begin
        val    = pc + WORD'(4);
        jump   = TRUE;
        target = {jalr_sum[WORD-1:1], 1'b0};
      end
      // Branches write no register; target is reported even when not taken.
      OPT_BEQ:  begin jump = (val1 == val2);                   target = br_tgt; end
      OPT_BNE:  begin jump = (val1 != val2);                   target = br_tgt; end
      OPT_BLT:  begin jump = ($signed(val1) <  $signed(val2)); target = br_tgt; end
      OPT_BGE:  begin jump = ($signed(val1) >= $signed(val2)); target = br_tgt; end
      OPT_BLTU: begin jump = (val1 <  val2);                   target = br_tgt; end
      OPT_BGEU: begin jump = (val1 >= val2);                   target = br_tgt; end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// Integer execution stage: computes dispatched ops, buffers results in a small
// queue and broadcasts the head on the ALU CDB channel under arbiter grant.
module alu_unit
  import alu_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  input  logic rb,
  alu_unit_if.slave bus
);

  localparam int unsigned PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

  alu_res_t          q_q [Q_DEPTH];
  alu_res_t          q_d [Q_DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  word_t    core_val;
  logic     core_jump;
  word_t    core_target;
  alu_res_t new_entry;
  alu_res_t head_entry;
  logic     push, pop, push_ok, not_empty;

  alu_core u_core (
    .opt    (bus.alu_opt),
    .val1   (bus.alu_val1),
    .val2   (bus.alu_val2),
    .imm    (bus.alu_imm),
    .pc     (bus.alu_pc),
    .val    (core_val),
    .jump   (core_jump),
    .target (core_target)
  );

  // Queue bookkeeping; a full queue still accepts a push if the head leaves the same cycle.
  always_comb begin
    q_d     = q_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    not_empty = (count_q != '0);
    push      = bus.alu_ena && rdy && !rb;
    pop       = not_empty && bus.cdb_gnt && rdy;
    push_ok   = push && ((count_q != CNT_W'(Q_DEPTH)) || pop);
    new_entry = '{rob_idx: bus.alu_rob_idx, val: core_val, jump: core_jump, target: core_target};

    if (rb) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        q_d[tail_q] = new_entry;
        tail_d      = PTR_W'(tail_q + PTR_W'(1));
      end
      if (pop) begin
        head_d = PTR_W'(head_q + PTR_W'(1));
      end
      case ({push_ok, pop})
        2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
        2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q     <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      q_q     <= q_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // CDB fields come straight from the registered head entry, blanked when empty.
  always_comb begin
    head_entry         = not_empty ? q_q[head_q] : '0;
    bus.cdb_alu_valid  = not_empty;
    bus.cdb_alu_src    = head_entry.rob_idx;
    bus.cdb_alu_val    = head_entry.val;
    bus.cdb_alu_jump   = head_entry.jump;
    bus.cdb_alu_target = head_entry.target;
    bus.alu_full       = (count_q >= CNT_W'(Q_DEPTH - 1));
  end

endmodule

// File: tb/tb_alu_unit.sv
// Directed bench for alu_unit: op table through the queue, then back-pressure,
// rollback, ready-hold and reset sequences.
module tb_alu_unit;
  import alu_unit_pkg::*;

  logic clk = 1'b0;
  logic rst, rdy, rb;
  int   vectors = 0;
  int   miscompares = 0;
  int   tb_occ = 0;

  alu_unit_if bus();

  alu_unit dut (.clk(clk), .rst(rst), .rdy(rdy), .rb(rb), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    INST_OPT     opt;
    logic [31:0] v1, v2, imm, pc;
    logic [31:0] ev;
    logic        ej;
    logic [31:0] et;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [3:0] src,
                         input logic [31:0] val, input logic j, input logic [31:0] tgt);
    chk($sformatf("%s.valid", tag),  32'(bus.cdb_alu_valid),  32'(v));
    chk($sformatf("%s.src", tag),    32'(bus.cdb_alu_src),    32'(src));
    chk($sformatf("%s.val", tag),    bus.cdb_alu_val,         val);
    chk($sformatf("%s.jump", tag),   32'(bus.cdb_alu_jump),   32'(j));
    chk($sformatf("%s.target", tag), bus.cdb_alu_target,      tgt);
  endtask

  task automatic drive(input INST_OPT opt, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] rob);
    bus.alu_ena     = 1'b1;
    bus.alu_opt     = opt;
    bus.alu_val1    = v1;
    bus.alu_val2    = v2;
    bus.alu_imm     = imm;
    bus.alu_pc      = pc;
    bus.alu_rob_idx = rob;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Flags any push the RS makes into an already full queue without a same-cycle pop.
  always @(posedge clk) begin
    logic p_push, p_pop;
    p_push = bus.alu_ena && rdy && !rb && !rst;
    p_pop  = bus.cdb_alu_valid && bus.cdb_gnt && rdy;
    if (p_push && !p_pop && tb_occ == int'(Q_DEPTH)) begin
      miscompares++;
      $display("FAIL overflow_push: occupancy %0d at push, allowed below %0d", tb_occ, Q_DEPTH);
    end
    if (rst || rb) tb_occ <= 0;
    else if (rdy) tb_occ <= tb_occ + (p_push ? 1 : 0) - ((p_pop && tb_occ > 0) ? 1 : 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; rb = 1'b0;
    bus.alu_ena = 1'b0; bus.alu_opt = OPT_NONE; bus.alu_val1 = '0; bus.alu_val2 = '0;
    bus.alu_imm = '0; bus.alu_pc = '0; bus.alu_rob_idx = '0; bus.cdb_gnt = 1'b0;

    vecs.push_back('{OPT_ADD,   32'd7,          32'd5,          32'd0,          32'h0,    32'd12,         1'b0, 32'h0});
    vecs.push_back('{OPT_SRA,   32'h8000_0000,  32'h21,         32'd0,          32'h0,    32'hC000_0000,  1'b0, 32'h0});
    vecs.push_back('{OPT_SLTU,  32'd1,          32'hFFFF_FFFF,  32'd0,          32'h0,    32'd1,          1'b0, 32'h0});
    vecs.push_back('{OPT_SLT,   32'd1,          32'hFFFF_FFFF,  32'd0,          32'h0,    32'd0,          1'b0, 32'h0});
    vecs.push_back('{OPT_BNE,   32'd1,          32'd2,          32'hFFFF_FFF8,  32'h100,  32'd0,          1'b1, 32'hF8});
    vecs.push_back('{OPT_JALR,  32'h203,        32'd0,          32'd0,          32'h400,  32'h404,        1'b1, 32'h202});
    vecs.push_back('{OPT_SUB,   32'd5,          32'd7,          32'd0,          32'h0,    32'hFFFF_FFFE,  1'b0, 32'h0});
    vecs.push_back('{OPT_SLLI,  32'd1,          32'd0,          32'h3F,         32'h0,    32'h8000_0000,  1'b0, 32'h0});
    vecs.push_back('{OPT_SRL,   32'h8000_0000,  32'd4,          32'd0,          32'h0,    32'h0800_0000,  1'b0, 32'h0});
    vecs.push_back('{OPT_SRAI,  32'hF000_0000,  32'd0,          32'd4,          32'h0,    32'hFF00_0000,  1'b0, 32'h0});
    vecs.push_back('{OPT_SLTI,  32'hFFFF_FFFB,  32'd0,          32'd3,          32'h0,    32'd1,          1'b0, 32'h0});
    vecs.push_back('{OPT_XORI,  32'hFF00_FF00,  32'd0,          32'hFFFF_FFFF,  32'h0,    32'h00FF_00FF,  1'b0, 32'h0});
    vecs.push_back('{OPT_ANDI,  32'h1234,       32'd0,          32'hFF,         32'h0,    32'h34,         1'b0, 32'h0});
    vecs.push_back('{OPT_ADD,   32'hFFFF_FFFF,  32'd2,          32'd0,          32'h0,    32'd1,          1'b0, 32'h0});
    vecs.push_back('{OPT_LUI,   32'd0,          32'd0,          32'h1234_5000,  32'h0,    32'h1234_5000,  1'b0, 32'h0});
    vecs.push_back('{OPT_AUIPC, 32'd0,          32'd0,          32'h2000,       32'h1000, 32'h3000,       1'b0, 32'h0});
    vecs.push_back('{OPT_JAL,   32'd0,          32'd0,          32'h20,         32'h10,   32'h14,         1'b1, 32'h30});
    vecs.push_back('{OPT_BEQ,   32'd3,          32'd4,          32'h10,         32'h200,  32'd0,          1'b0, 32'h210});
    vecs.push_back('{OPT_BGE,   32'hFFFF_FFFF,  32'd1,          32'h8,          32'h300,  32'd0,          1'b0, 32'h308});
    vecs.push_back('{OPT_BLTU,  32'd1,          32'hFFFF_FFFF,  32'h8,          32'h300,  32'd0,          1'b1, 32'h308});
    vecs.push_back('{INST_OPT'(6'd63), 32'd9,   32'd9,          32'd9,          32'h40,   32'd0,          1'b0, 32'h0});

    tick(); tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("reset.full", 32'(bus.alu_full), 32'd0);

    // Table: each op appears the cycle after dispatch and leaves after one granted cycle.
    foreach (vecs[i]) begin
      logic [3:0] rob;
      rob = 4'((i % 15) + 1);
      drive(vecs[i].opt, vecs[i].v1, vecs[i].v2, vecs[i].imm, vecs[i].pc, rob);
      bus.cdb_gnt = 1'b1;
      tick();
      bus.alu_ena = 1'b0;
      chk_out($sformatf("vec%0d", i), 1'b1, rob, vecs[i].ev, vecs[i].ej, vecs[i].et);
      tick();
      chk($sformatf("vec%0d.drained", i), 32'(bus.cdb_alu_valid), 32'd0);
    end

    // Back-pressure: two entries held without grant, then drained in order.
    bus.cdb_gnt = 1'b0;
    drive(OPT_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd1);
    tick();
    chk("bp.full1", 32'(bus.alu_full), 32'd1);
    chk_out("bp.hold1", 1'b1, 4'd1, 32'd2, 1'b0, 32'd0);
    drive(OPT_ADD, 32'd2, 32'd3, 32'd0, 32'd0, 4'd2);
    tick();
    bus.alu_ena = 1'b0;
    chk_out("bp.hold2", 1'b1, 4'd1, 32'd2, 1'b0, 32'd0);
    tick();
    chk_out("bp.still", 1'b1, 4'd1, 32'd2, 1'b0, 32'd0);
    bus.cdb_gnt = 1'b1;
    tick();
    chk_out("bp.pop1", 1'b1, 4'd2, 32'd5, 1'b0, 32'd0);
    chk("bp.full2", 32'(bus.alu_full), 32'd1);
    tick();
    chk("bp.empty", 32'(bus.cdb_alu_valid), 32'd0);
    chk("bp.full3", 32'(bus.alu_full), 32'd0);

    // Rollback with two queued entries and a same-cycle dispatch.
    bus.cdb_gnt = 1'b0;
    drive(OPT_ADD, 32'd1, 32'd0, 32'd0, 32'd0, 4'd3);
    tick();
    drive(OPT_ADD, 32'd2, 32'd0, 32'd0, 32'd0, 4'd4);
    tick();
    chk("rb.pre_full", 32'(bus.alu_full), 32'd1);
    rb = 1'b1;
    bus.cdb_gnt = 1'b1;
    drive(OPT_ADD, 32'd5, 32'd0, 32'd0, 32'd0, 4'd5);
    tick();
    rb = 1'b0;
    bus.alu_ena = 1'b0;
    chk("rb.valid", 32'(bus.cdb_alu_valid), 32'd0);
    chk("rb.full", 32'(bus.alu_full), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rb.quiet%0d", k), 32'(bus.cdb_alu_valid), 32'd0);
    end

    // Ready low freezes the queue: no pop under grant, no push of a dispatched op.
    bus.cdb_gnt = 1'b0;
    drive(OPT_ADD, 32'd10, 32'd20, 32'd0, 32'd0, 4'd7);
    tick();
    rdy = 1'b0;
    bus.cdb_gnt = 1'b1;
    drive(OPT_ADD, 32'd1, 32'd1, 32'd0, 32'd0, 4'd8);
    tick();
    chk_out("rdy.hold1", 1'b1, 4'd7, 32'd30, 1'b0, 32'd0);
    tick();
    chk_out("rdy.hold2", 1'b1, 4'd7, 32'd30, 1'b0, 32'd0);
    rdy = 1'b1;
    bus.alu_ena = 1'b0;
    bus.cdb_gnt = 1'b0;
    tick();
    chk_out("rdy.resume", 1'b1, 4'd7, 32'd30, 1'b0, 32'd0);
    chk("rdy.full", 32'(bus.alu_full), 32'd1);

    // Reset mid-stream wins over a concurrent dispatch.
    rst = 1'b1;
    drive(OPT_JAL, 32'd0, 32'd0, 32'h20, 32'h10, 4'd9);
    tick();
    rst = 1'b0;
    bus.alu_ena = 1'b0;
    chk_out("rst.mid", 1'b0, 4'd0, 32'd0, 1'b0, 32'd0);
    chk("rst.full", 32'(bus.alu_full), 32'd0);
    tick();
    chk("rst.after", 32'(bus.cdb_alu_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
Name: alu_unit

Overview:
- Integer execution stage directly downstream of the reservation station.
- Accepts one dispatched op per cycle (operands already resolved) and computes the RV32I integer, branch or jump result.
- Buffers results in a small output queue and broadcasts them on the ALU CDB channel under an arbiter grant.
- Provides back-pressure to the RS (into its stall input) and flushes on rollback.

Parameters:
- ROB_BIT, 4, ROB index width; index 0 is reserved and means "no dependency".
- OPT_BIT, 6, width of the op-code field.
- Q_DEPTH, 2, result queue entries (power of two, ≥2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; low = hold all state
- rb  in  1  rollback/flush
- alu_ena  in  1  op valid this cycle
- alu_opt  in  OPT_BIT  op-code (shared package constants)
- alu_val1  in  32  rs1 value
- alu_val2  in  32  rs2 value
- alu_imm  in  32  sign-extended immediate
- alu_pc  in  32  instruction pc, forwarded by RS alongside imm
- alu_rob_idx  in  ROB_BIT  destination ROB entry, nonzero
- alu_full  out  1  RS must not dispatch next cycle
- cdb_gnt  in  1  arbiter accepts head this cycle
- cdb_alu_valid  out  1  head valid
- cdb_alu_src  out  ROB_BIT  head ROB index
- cdb_alu_val  out  32  head result (rd value)
- cdb_alu_jump  out  1  control transfer taken
- cdb_alu_target  out  32  taken target

Behaviour:
- Reset (rst=1, takes priority over everything):
  - queue emptied, count=0, all outputs 0.
  - Outputs are driven from the head entry, which is zeroed on reset.
- rdy=0 (and no rst): no push, no pop, state and outputs held.
- Compute (combinational, same cycle alu_ena sampled):
  - ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND use val1 op val2.
  - The *I variants use val1 op imm.
  - Shifts use only the low 5 bits of the shift amount. SRA is arithmetic.
  - SLT is signed and SLTU is unsigned; both give 1/0.
  - All arithmetic is mod 2^32.
  - LUI: val=imm.
  - AUIPC: val=pc+imm.
  - JAL: val=pc+4, jump=1, target=pc+imm.
  - JALR: val=pc+4, jump=1, target=(val1+imm)&~1.
  - BEQ/BNE/BLT/BGE/BLTU/BGEU: val=0, jump=condition, target=pc+imm.
  - Non-jump ops: jump=0, target=0.
  - Unknown opt: val=0, jump=0, still pushed so the ROB entry completes.
- Push: alu_ena && rdy && !rb writes {rob_idx,val,jump,target} at the tail on the clock edge.
- Latency: op sampled at edge N appears on the CDB outputs after edge N (visible during cycle N+1) when the queue was empty. No combinational bypass.
- Output: cdb_alu_valid = (count!=0); the other cdb_* fields show the head entry, and are 0 when empty.
- Pop: cdb_alu_valid && cdb_gnt && rdy advances head at the edge. The entry remains presented until granted.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance.
- Pointers wrap modulo Q_DEPTH.
- alu_full = (count ≥ Q_DEPTH-1), registered-count based. This gives one slot of headroom for the op already in flight from the registered RS output.
- Push at count==Q_DEPTH is a protocol violation: the push is ignored, count saturates, and the bench asserts on it.
- rb=1:
  - queue cleared, count=0, cdb_alu_valid=0 from next cycle.
  - Any alu_ena in the same cycle is discarded.
  - A grant in the same cycle is irrelevant.
- rst and rb behave identically except that rst also forces all outputs to 0.

Decomposition:
- Shared package (utils) holds:
  - WORD width and ZERO_WORD,
  - ROB_IDX type and ZERO_ROB_IDX,
  - INST_OPT type and every OPT_* encoding including OPT_NONE,
  - TRUE/FALSE.
- One sub-module, alu_core: purely combinational (opt,val1,val2,imm,pc) -> (val,jump,target).
- alu_unit wraps alu_core with the queue, counter and handshake.

Test Plan:
- Basic ADD: ADD val1=7, val2=5, rob=3, cdb_gnt=1 -> next cycle valid=1, src=3, val=12, jump=0; valid=0 the cycle after.
- Arithmetic boundaries: SRA val1=0x80000000, val2=0x21 -> val=0xC0000000 (shamt 1). SLTU 1 vs 0xFFFFFFFF -> 1. SLT same -> 0.
- Control flow:
  - BNE pc=0x100, imm=-8, val1=1, val2=2 -> jump=1, target=0xF8, val=0.
  - JALR val1=0x203, imm=0 -> target=0x202, val=pc+4.
- Back-pressure: hold cdb_gnt=0, issue ops rob=1 then rob=2 -> alu_full=1 after first push; both retained. Raise gnt -> src=1 then src=2 on consecutive cycles; alu_full drops.
- Rollback: two entries queued, rb=1 with alu_ena=1 rob=5 -> next cycle valid=0, count=0; rob 5 never broadcast.
- Ready and reset: rdy=0 with gnt=1 and entry queued -> outputs held, no pop. Assert rst mid-stream -> all outputs 0 next cycle.
